// File: rtl/n_bit_1_to_4_demux_stream_if.sv
// Handshake bundle for the 1-to-4 stream demux: one producer side and four
// consumer slots. The producer/consumer bench uses master, the demux uses slave.
interface n_bit_1_to_4_demux_stream_if #(
    parameter int N = 4
);
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   select;
    logic [N-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [N-1:0] y0;
    logic [N-1:0] y1;
    logic [N-1:0] y2;
    logic [N-1:0] y3;

    modport master (
        output enable, in_valid, select, in_data, out_ready,
        input  in_ready, out_valid, y0, y1, y2, y3
    );

    modport slave (
        input  enable, in_valid, select, in_data, out_ready,
        output in_ready, out_valid, y0, y1, y2, y3
    );
endinterface

// File: rtl/n_bit_1_to_4_demux_stream.sv
// Registered N-bit 1-to-4 demux with one single-entry slot per channel.
// Optional macro DEMUX_ZERO_IDLE_EN: EMPTY slots drive zeros on y0..y3.
module n_bit_1_to_4_demux_stream #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    n_bit_1_to_4_demux_stream_if.slave    bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e  state_q [4];
    slot_state_e  state_d [4];
    logic [N-1:0] data_q  [4];
    logic [N-1:0] data_d  [4];
    logic [N-1:0] y_shown [4];
    logic         in_ready_c;
    logic         in_xfer_c;

    // A full slot can take a new word only if its consumer drains it this cycle.
    always_comb begin
        in_ready_c = 1'b0;
        in_xfer_c  = 1'b0;
        in_ready_c = bus.enable &&
                     ((state_q[bus.select] == EMPTY) || bus.out_ready[bus.select]);
        in_xfer_c  = bus.in_valid && in_ready_c;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if ((state_q[k] == FULL) && bus.out_ready[k]) begin
                state_d[k] = EMPTY;
            end
            // A simultaneous load wins over the drain: old word consumed, new word held.
            if (in_xfer_c && (bus.select == 2'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
`ifdef DEMUX_ZERO_IDLE_EN
            y_shown[k] = (state_q[k] == FULL) ? data_q[k] : '0;
`else
            y_shown[k] = data_q[k];
`endif
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid[0] = (state_q[0] == FULL);
    assign bus.out_valid[1] = (state_q[1] == FULL);
    assign bus.out_valid[2] = (state_q[2] == FULL);
    assign bus.out_valid[3] = (state_q[3] == FULL);
    assign bus.y0           = y_shown[0];
    assign bus.y1           = y_shown[1];
    assign bus.y2           = y_shown[2];
    assign bus.y3           = y_shown[3];

endmodule
